// File: rtl/logic_clock_domain_crossing_read_arbiter.sv
// Round-robin read arbiter sharing one registered AXI4-Stream egress between CHANNELS CDC FIFO read sides.
// Define LOGIC_CLOCK_DOMAIN_CROSSING_READ_ARBITER_PACKET_LOCK_EN to hold the grant for a whole packet; otherwise arbitration is per beat.
module logic_clock_domain_crossing_read_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH  = $clog2(CHANNELS)
) (
  input  logic                           tx_aclk,
  input  logic                           tx_areset_n,
  input  logic [CHANNELS-1:0]            rx_tvalid,
  input  logic [CHANNELS-1:0]            rx_tlast,
  input  logic [CHANNELS*DATA_WIDTH-1:0] rx_tdata,
  output logic [CHANNELS-1:0]            rx_tready,
  output logic                           tx_tvalid,
  output logic                           tx_tlast,
  output logic [DATA_WIDTH-1:0]          tx_tdata,
  output logic [ID_WIDTH-1:0]            tx_tid,
  input  logic                           tx_tready
);

  if (CHANNELS < 2 || DATA_WIDTH < 1) begin : g_drc
    $error("logic_clock_domain_crossing_read_arbiter: CHANNELS >= 2 and DATA_WIDTH >= 1 required");
  end

  localparam logic [0:0] FSM_IDLE = 1'b0;
  localparam logic [0:0] FSM_BUSY = 1'b1;

  logic [0:0]            state_r;
  logic [0:0]            state_nxt_s;
  logic [ID_WIDTH-1:0]   grant_r;
  logic [ID_WIDTH-1:0]   last_grant_r;
  logic [ID_WIDTH-1:0]   pick_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  out_free_s;
  logic                  accept_s;

  // First requester strictly after the previous winner, wrapping, so the previous winner ranks last.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [CHANNELS-1:0] req,
                                                  input logic [ID_WIDTH-1:0] last);
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    int                  idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(last) + i) % CHANNELS;
      if (!found && req[ID_WIDTH'(idx)]) begin
        pick  = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(rx_tvalid, last_grant_r);

  // Mux the granted channel and decide whether its beat is taken this cycle.
  always_comb begin
    sel_valid_s = rx_tvalid[grant_r];
    sel_last_s  = rx_tlast[grant_r];
    sel_data_s  = rx_tdata[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
    out_free_s  = !tx_tvalid || tx_tready;
    accept_s    = (state_r == FSM_BUSY) && sel_valid_s && out_free_s;
  end

  // Only the granted channel sees ready, and only while the output register can take a beat.
  always_comb begin
    rx_tready = {CHANNELS{1'b0}};
    if (state_r == FSM_BUSY) begin
      rx_tready[grant_r] = out_free_s;
    end else begin
      rx_tready = {CHANNELS{1'b0}};
    end
  end

  // Next-state logic; the release point differs between packet-locked and beat-level arbitration.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FSM_IDLE: begin
        if (|rx_tvalid) begin
          state_nxt_s = FSM_BUSY;
        end else begin
          state_nxt_s = FSM_IDLE;
        end
      end
      FSM_BUSY: begin
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_READ_ARBITER_PACKET_LOCK_EN
        if (accept_s && sel_last_s) begin
`else
        if (accept_s) begin
`endif
          state_nxt_s = FSM_IDLE;
        end else begin
          state_nxt_s = FSM_BUSY;
        end
      end
      default: state_nxt_s = FSM_IDLE;
    endcase
  end

  // FSM state plus grant and round-robin pointer, captured during the idle arbitration cycle.
  always_ff @(posedge tx_aclk or negedge tx_areset_n) begin
    if (!tx_areset_n) begin
      state_r      <= FSM_IDLE;
      grant_r      <= {ID_WIDTH{1'b0}};
      last_grant_r <= ID_WIDTH'(CHANNELS - 1);
    end else begin
      state_r <= state_nxt_s;
      if (state_r == FSM_IDLE && |rx_tvalid) begin
        grant_r      <= pick_s;
        last_grant_r <= pick_s;
      end
    end
  end

  // Output handshake register: load on accept, empty on a downstream handshake with nothing new.
  always_ff @(posedge tx_aclk or negedge tx_areset_n) begin
    if (!tx_areset_n) begin
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_tid    <= {ID_WIDTH{1'b0}};
    end else if (accept_s) begin
      tx_tvalid <= 1'b1;
      tx_tlast  <= sel_last_s;
      tx_tid    <= grant_r;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

  // Payload register carries no reset; it is only meaningful while tx_tvalid is high.
  always_ff @(posedge tx_aclk) begin
    if (accept_s) begin
      tx_tdata <= sel_data_s;
    end
  end

endmodule

// File: tb/tb_logic_clock_domain_crossing_read_arbiter.sv
// Self-checking bench: per-channel scoreboard plus a cycle model of the arbiter's rules, directed and random traffic.
// Follows LOGIC_CLOCK_DOMAIN_CROSSING_READ_ARBITER_PACKET_LOCK_EN the same way the design does.
module tb_logic_clock_domain_crossing_read_arbiter;
  localparam int CH = 4;
  localparam int DW = 8;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_READ_ARBITER_PACKET_LOCK_EN
  localparam bit PKT_LOCK = 1'b1;
  localparam int BEAT_GAP = 1;
  localparam int EXP_INTERLEAVE = 0;
`else
  localparam bit PKT_LOCK = 1'b0;
  localparam int BEAT_GAP = 2;
  localparam int EXP_INTERLEAVE = 1;
`endif

  logic              tx_aclk = 1'b0;
  logic              tx_areset_n;
  logic [CH-1:0]     rx_tvalid;
  logic [CH-1:0]     rx_tlast;
  logic [CH*DW-1:0]  rx_tdata;
  logic [CH-1:0]     rx_tready;
  logic              tx_tvalid;
  logic              tx_tlast;
  logic [DW-1:0]     tx_tdata;
  logic [1:0]        tx_tid;
  logic              tx_tready;

  logic_clock_domain_crossing_read_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
    .tx_aclk(tx_aclk), .tx_areset_n(tx_areset_n),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata), .tx_tid(tx_tid),
    .tx_tready(tx_tready)
  );

  always #5 tx_aclk = ~tx_aclk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int p_valid = 100;
  int rdy_mode = 1;           // 0: hold low, 1: hold high, 2: random
  int exp_order[10];

  // Upstream FIFO contents and accepted-but-undelivered beats; a beat is (last<<8)|data.
  int src_q[CH][$];
  int sb_q[CH][$];
  bit pres[CH];
  bit hs_in[CH];
  int log_tid[$], log_data[$], log_last[$], log_cyc[$];

  // Reference model: who owns the egress (-1 while arbitrating), last winner, output slot.
  int m_owner, m_ptr, m_od, m_oid;
  bit m_ov, m_ol;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int log_at(input int kind, input int i);
    if (i >= log_tid.size()) return -1;
    case (kind)
      0: return log_tid[i];
      1: return log_data[i];
      2: return log_last[i];
      default: return log_cyc[i];
    endcase
  endfunction

  task automatic enq(input int c, input int data, input bit last);
    src_q[c].push_back((last ? 256 : 0) + (data & 255));
  endtask

  task automatic send_pkt(input int c, input int base, input int len);
    for (int i = 0; i < len; i++) enq(c, base + i, i == len - 1);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = CH - 1; m_ov = 0; m_ol = 0; m_od = 0; m_oid = 0;
  endtask

  // Compare every output against the model, score handshakes, then advance the model past the coming edge.
  task automatic compare();
    logic [CH-1:0] er;
    int beat, exp, c;
    bit acc;
    er = '0;
    if (m_owner >= 0) er[m_owner] = !m_ov || tx_tready;
    chk("rx_tready", int'(rx_tready), int'(er));
    chk("tx_tvalid", int'(tx_tvalid), int'(m_ov));
    chk("tx_tlast", int'(tx_tlast), int'(m_ol));
    chk("tx_tid", int'(tx_tid), m_oid);
    if (m_ov) chk("tx_tdata", int'(tx_tdata), m_od);
    if (tx_tvalid && tx_tready) begin
      beat = (tx_tlast ? 256 : 0) + int'(tx_tdata);
      exp = -1;
      if (sb_q[tx_tid].size() > 0) exp = sb_q[tx_tid].pop_front();
      chk("sb_beat", beat, exp);
      log_tid.push_back(int'(tx_tid)); log_data.push_back(int'(tx_tdata));
      log_last.push_back(int'(tx_tlast)); log_cyc.push_back(cyc);
    end
    for (int k = 0; k < CH; k++) begin
      hs_in[k] = rx_tvalid[k] && rx_tready[k];
      if (hs_in[k]) sb_q[k].push_back((rx_tlast[k] ? 256 : 0) + int'(rx_tdata[k*DW +: DW]));
    end
    acc = (m_owner >= 0) && rx_tvalid[m_owner] && er[m_owner];
    if (m_owner < 0) begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_ptr + k) % CH;
        if (m_owner < 0 && rx_tvalid[c]) m_owner = c;
      end
      if (m_owner >= 0) m_ptr = m_owner;
    end else if (acc) begin
      m_ov = 1; m_od = int'(rx_tdata[m_owner*DW +: DW]); m_ol = rx_tlast[m_owner]; m_oid = m_owner;
      if (!PKT_LOCK || rx_tlast[m_owner]) m_owner = -1;
    end
    if (!acc && m_ov && tx_tready) m_ov = 0;
  endtask

  // One clock: drive after the edge, check at the falling edge.
  task automatic step();
    int b;
    @(posedge tx_aclk); #1;
    cyc++;
    for (int c = 0; c < CH; c++) begin
      if (hs_in[c] && src_q[c].size() > 0) begin
        void'(src_q[c].pop_front());
        pres[c] = 0;
      end
      hs_in[c] = 0;
      if (!pres[c] && src_q[c].size() > 0 && int'($urandom_range(99)) < p_valid) pres[c] = 1;
      rx_tvalid[c] = pres[c];
      if (src_q[c].size() > 0) begin
        b = src_q[c][0];
        rx_tdata[c*DW +: DW] = b[7:0];
        rx_tlast[c] = b[8];
      end else begin
        rx_tdata[c*DW +: DW] = DW'($urandom);
        rx_tlast[c] = 1'b0;
      end
    end
    case (rdy_mode)
      0: tx_tready = 1'b0;
      1: tx_tready = 1'b1;
      default: tx_tready = 1'($urandom_range(1));
    endcase
    @(negedge tx_aclk);
    compare();
  endtask

  task automatic do_reset();
    tx_areset_n = 1'b0;
    rx_tvalid = '0; rx_tlast = '0; rx_tdata = '0; tx_tready = 1'b0;
    for (int c = 0; c < CH; c++) begin
      src_q[c].delete(); sb_q[c].delete(); pres[c] = 0; hs_in[c] = 0;
    end
    log_tid.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
    #2;
    chk("reset_tx_tvalid", int'(tx_tvalid), 0);
    chk("reset_rx_tready", int'(rx_tready), 0);
    model_reset();
    repeat (2) @(posedge tx_aclk);
    #1 tx_areset_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    bit busy = 1;
    while (busy && n < 3000) begin
      busy = tx_tvalid;
      for (int c = 0; c < CH; c++) if (src_q[c].size() > 0 || sb_q[c].size() > 0) busy = 1;
      if (busy) begin step(); n++; end
    end
    chk("drain_timeout", int'(n < 3000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, n, first3, last0;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_READ_ARBITER_PACKET_LOCK_EN
    exp_order = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
`endif
    do_reset();

    // Single channel 2 packet: latency, spacing, tid and tlast placement.
    rdy_mode = 1; p_valid = 100;
    enq(2, 8'hA1, 0); enq(2, 8'hA2, 0); enq(2, 8'hA3, 1);
    step(); rise = cyc;
    drain();
    chk("a_count", log_tid.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("a_tid", log_at(0, i), 2);
      chk("a_data", log_at(1, i), 8'hA1 + i);
      chk("a_last", log_at(2, i), int'(i == 2));
    end
    chk("a_latency", log_at(3, 0) - rise, 2);
    chk("a_gap1", log_at(3, 1) - log_at(3, 0), BEAT_GAP);
    chk("a_gap2", log_at(3, 2) - log_at(3, 1), BEAT_GAP);

    // All channels streaming 2-beat packets: round-robin order.
    do_reset();
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < 3; p++) send_pkt(c, c * 64 + p * 8, 2);
    drain();
    for (int i = 0; i < 10; i++) chk("b_order", log_at(0, i), exp_order[i]);

    // Output stall on channel 1 with 0x55 held.
    do_reset();
    rdy_mode = 0;
    enq(1, 8'h55, 0); enq(1, 8'h56, 1);
    n = 0;
    while (!tx_tvalid && n < 20) begin step(); n++; end
    chk("c_valid_seen", int'(tx_tvalid), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("c_hold_valid", int'(tx_tvalid), 1);
      chk("c_hold_data", int'(tx_tdata), 8'h55);
      chk("c_hold_tid", int'(tx_tid), 1);
      chk("c_hold_last", int'(tx_tlast), 0);
      chk("c_hold_ready1", int'(rx_tready[1]), 0);
    end
    rdy_mode = 1;
    drain();
    chk("c_data0", log_at(1, 0), 8'h55);
    chk("c_data1", log_at(1, 1), 8'h56);

    // Channel 0 gaps mid-packet while channel 3 requests.
    do_reset();
    enq(0, 8'hD0, 0);
    n = 0;
    while (log_tid.size() < 1 && n < 20) begin step(); n++; end
    chk("d_first_seen", log_tid.size(), 1);
    enq(3, 8'hE0, 0); enq(3, 8'hE1, 1);
    repeat (3) step();
    enq(0, 8'hD1, 0); enq(0, 8'hD2, 1);
    drain();
    chk("d_count", log_tid.size(), 5);
    first3 = -1; last0 = -1;
    for (int i = 0; i < log_tid.size(); i++) begin
      if (log_tid[i] == 3 && first3 < 0) first3 = i;
      if (log_tid[i] == 0) last0 = i;
    end
    chk("d_interleave", int'(first3 >= 0 && first3 < last0), EXP_INTERLEAVE);

    // Reset mid-packet, then the lowest-index requester wins first.
    do_reset();
    send_pkt(2, 8'h70, 4);
    repeat (4) step();
    do_reset();
    enq(3, 8'h33, 1); enq(1, 8'h11, 1);
    drain();
    chk("e_first", log_at(0, 0), 1);
    chk("e_second", log_at(0, 1), 3);

    // Channel 0 raises valid as channel 3's tlast is taken: wrap to 0, then 1.
    do_reset();
    enq(2, 8'h20, 1);
    step();
    enq(1, 8'h10, 1); enq(3, 8'h30, 1);
    step(); step();
    enq(0, 8'h00, 1);
    step();
    drain();
    chk("f_g0", log_at(0, 0), 2);
    chk("f_g1", log_at(0, 1), 3);
    chk("f_g2", log_at(0, 2), 0);
    chk("f_g3", log_at(0, 3), 1);

    // Random traffic with random valid gaps and backpressure, one reset mid-run.
    do_reset();
    rdy_mode = 2; p_valid = 60;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(99) < 20) begin
        n = int'($urandom_range(CH - 1));
        if (src_q[n].size() < 8) send_pkt(n, int'($urandom_range(255)), int'($urandom_range(4, 1)));
      end
      if (t == 400) do_reset();
      step();
    end
    rdy_mode = 1; p_valid = 100;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
